imu_poll_ctrl: RTL and testbench

//  Periodic scheduler and result latch for jb_imu. Issues jb_imu start pulses at a fixed poll rate,

---
 rtl/imu_poll_pkg.sv | 44 ++++
 rtl/imu_poll_tick.sv | 39 +++
 rtl/imu_poll_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_imu_poll_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_poll_pkg.sv
//==============================================================================
// Module   : imu_poll_pkg
// Purpose  : Shared types and constants for the jb_imu poll controller:
//            FSM state encoding, IMU bus geometry and word packing indices.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package imu_poll_pkg;

  localparam int IMU_WORDS  = 9;
  localparam int IMU_WORD_W = 16;
  localparam int IMU_BUS_W  = IMU_WORDS * IMU_WORD_W;

  // Word order on the bus, index 0 is the most significant word (roll)
  localparam int IDX_ROLL       = 0;
  localparam int IDX_PITCH      = 1;
  localparam int IDX_YAW        = 2;
  localparam int IDX_ROLL_RATE  = 3;
  localparam int IDX_PITCH_RATE = 4;
  localparam int IDX_YAW_RATE   = 5;
  localparam int IDX_ACCEL_X    = 6;
  localparam int IDX_ACCEL_Y    = 7;
  localparam int IDX_ACCEL_Z    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    LATCH     = 3'd4,
    FAULT     = 3'd5
  } poll_state_t;

  // Extract one 16-bit word from a packed IMU bus by its word index
  function automatic logic [IMU_WORD_W-1:0] imu_word(input logic [IMU_BUS_W-1:0] bus,
                                                    input int idx);
    return bus[(IMU_WORDS-1-idx)*IMU_WORD_W +: IMU_WORD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/imu_poll_tick.sv
//==============================================================================
// Module   : imu_poll_tick
// Purpose  : Poll-rate divider. Counts 0..POLL_DIV-1 while enabled and emits a
//            one-cycle tick on the last count; held at zero while disabled.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module imu_poll_tick #(
  parameter int POLL_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int                 c_cnt_w = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(POLL_DIV - 1);

  logic [c_cnt_w-1:0] r_count;

  // Free-running divider, parked at zero whenever polling is disabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!i_enable || (r_count == c_last)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = i_enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/imu_poll_ctrl.sv
//==============================================================================
// Module   : imu_poll_ctrl
// Purpose  : Periodic scheduler and result latch for jb_imu. Issues start
//            pulses at the poll rate, supervises done with timeout and bounded
//            retry, and snapshots the nine IMU words into a coherent bank.
// Options  : IMU_STALE_CHECK_EN - suppress samples identical to the last one
//            and count them on stale_count.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module imu_poll_ctrl
  import imu_poll_pkg::*;
#(
  parameter int POLL_DIV    = 50000,
  parameter int TIMEOUT_CYC = 20000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 imu_start,
  input  logic                 imu_done,
  input  logic [IMU_BUS_W-1:0] imu_data,
  output logic [IMU_BUS_W-1:0] sample,
  output logic                 sample_valid,
  output logic [15:0]          sample_count,
  output logic [7:0]           overrun_count,
  output logic                 busy,
  output logic                 fault
`ifdef IMU_STALE_CHECK_EN
  ,
  output logic [7:0]           stale_count
`endif
);

  localparam int                 c_to_w      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(TIMEOUT_CYC - 1);
  localparam logic [2:0]         c_max_retry = 3'(MAX_RETRY);

  poll_state_t          r_state;
  poll_state_t          w_next;
  logic [c_to_w-1:0]    r_to_cnt;
  logic [2:0]           r_retry;
  logic [IMU_BUS_W-1:0] r_sample;
  logic                 r_sample_valid;
  logic [15:0]          r_sample_count;
  logic [7:0]           r_overrun;
  logic                 w_tick;
  logic                 w_busy;
  logic                 w_timeout;
  logic                 w_done_seen;
  logic                 w_stale;
  logic                 w_accept;
  logic                 w_retry_now;

  imu_poll_tick #(
    .POLL_DIV (POLL_DIV)
  ) u_tick (
    .clock    (clock),
    .reset    (reset),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  assign w_busy      = (r_state == START) || (r_state == WAIT_DONE) || (r_state == LATCH);
  assign w_timeout   = (r_to_cnt == c_to_last);
  // Data is captured on the edge that enters LATCH so sample and valid appear together
  assign w_done_seen = (r_state == WAIT_DONE) && imu_done;

`ifdef IMU_STALE_CHECK_EN
  assign w_stale = (imu_data == r_sample) && (r_sample_count != 16'd0);
`else
  assign w_stale = 1'b0;
`endif

  assign w_accept    = w_done_seen && !w_stale;
  assign w_retry_now = (r_state == WAIT_DONE) && !imu_done && w_timeout && enable &&
                       (r_retry < c_max_retry);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a disabled controller still finishes its transaction
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (enable) w_next = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)     w_next = IDLE;
        else if (w_tick) w_next = START;
      end
      START:     w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (imu_done)         w_next = LATCH;
        else if (w_timeout) begin
          if (!enable)        w_next = IDLE;
          else if (w_retry_now) w_next = START;
          else                w_next = FAULT;
        end
      end
      LATCH:     w_next = enable ? WAIT_TICK : IDLE;
      FAULT:     if (!enable) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Timeout counter: cleared on every start, advances while waiting for done
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state == START) begin
      r_to_cnt <= '0;
    end else if ((r_state == WAIT_DONE) && !imu_done) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Retry budget: refilled after a successful latch or on return to idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_retry <= '0;
    end else if ((r_state == IDLE) || (r_state == LATCH)) begin
      r_retry <= '0;
    end else if (w_retry_now) begin
      r_retry <= r_retry + 1'b1;
    end
  end

  // Sample bank: all 144 bits load together with the valid strobe and count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_sample_count <= '0;
    end else begin
      r_sample_valid <= w_accept;
      if (w_accept) begin
        r_sample       <= imu_data;
        r_sample_count <= r_sample_count + 16'd1;
      end
    end
  end

  // Overrun counter: ticks arriving mid-transaction are dropped and counted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overrun <= '0;
    end else if (w_tick && w_busy && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

`ifdef IMU_STALE_CHECK_EN
  logic [7:0] r_stale_count;

  // Stale counter: completed transactions whose data repeated the held sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stale_count <= '0;
    end else if (w_done_seen && w_stale && (r_stale_count != 8'hFF)) begin
      r_stale_count <= r_stale_count + 8'd1;
    end
  end

  assign stale_count = r_stale_count;
`endif

  assign imu_start     = (r_state == START);
  assign busy          = w_busy;
  assign fault         = (r_state == FAULT);
  assign sample        = r_sample;
  assign sample_valid  = r_sample_valid;
  assign sample_count  = r_sample_count;
  assign overrun_count = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_imu_poll_ctrl.sv
//==============================================================================
// Module   : tb_imu_poll_ctrl
// Purpose  : Self-checking bench for imu_poll_ctrl with behavioural jb_imu
//            stubs. A second instance with a short poll period and a stub that
//            ignores the first request of each transaction exercises overrun.
// Options  : IMU_STALE_CHECK_EN - selects the stale-suppression expectations.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imu_poll_ctrl;
  import imu_poll_pkg::*;

  localparam int POLL_DIV    = 200;
  localparam int TIMEOUT_CYC = 50;
  localparam int MAX_RETRY   = 2;
  localparam int POLL_DIV_2  = 60;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic                 reset;
  logic                 enable;
  logic                 imu_start;
  logic                 imu_done = 1'b0;
  logic [IMU_BUS_W-1:0] imu_data = '0;
  logic [IMU_BUS_W-1:0] sample;
  logic                 sample_valid;
  logic [15:0]          sample_count;
  logic [7:0]           overrun_count;
  logic                 busy;
  logic                 fault;

  logic                 enable_2;
  logic                 imu_start_2;
  logic                 imu_done_2 = 1'b0;
  logic [IMU_BUS_W-1:0] imu_data_2 = '0;
  logic [IMU_BUS_W-1:0] sample_2;
  logic                 sample_valid_2;
  logic [15:0]          sample_count_2;
  logic [7:0]           overrun_count_2;
  logic                 busy_2;
  logic                 fault_2;
`ifdef IMU_STALE_CHECK_EN
  logic [7:0]           stale_count;
  logic [7:0]           stale_count_2;
`endif

  imu_poll_ctrl #(
    .POLL_DIV    (POLL_DIV),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .imu_start     (imu_start),
    .imu_done      (imu_done),
    .imu_data      (imu_data),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .sample_count  (sample_count),
    .overrun_count (overrun_count),
    .busy          (busy),
    .fault         (fault)
`ifdef IMU_STALE_CHECK_EN
    ,
    .stale_count   (stale_count)
`endif
  );

  imu_poll_ctrl #(
    .POLL_DIV    (POLL_DIV_2),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut_2 (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable_2),
    .imu_start     (imu_start_2),
    .imu_done      (imu_done_2),
    .imu_data      (imu_data_2),
    .sample        (sample_2),
    .sample_valid  (sample_valid_2),
    .sample_count  (sample_count_2),
    .overrun_count (overrun_count_2),
    .busy          (busy_2),
    .fault         (fault_2)
`ifdef IMU_STALE_CHECK_EN
    ,
    .stale_count   (stale_count_2)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [IMU_BUS_W-1:0] obs,
                     input logic [IMU_BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IMU_BUS_W-1:0] rand_bus();
    logic [IMU_BUS_W-1:0] r;
    for (int k = 0; k < IMU_WORDS; k++) r[k*IMU_WORD_W +: IMU_WORD_W] = 16'($urandom);
    return r;
  endfunction

  // jb_imu stub for the main instance: done one cycle, stub_delay cycles after start
  int                   stub_remain = 0;
  int                   stub_delay  = 20;
  bit                   stub_never  = 1'b0;
  logic [IMU_BUS_W-1:0] stub_data   = '0;

  always @(negedge clock) begin
    imu_done = 1'b0;
    if (!reset) begin
      stub_remain = 0;
    end else begin
      if (stub_remain > 0) begin
        stub_remain--;
        if (stub_remain == 0) begin
          imu_data = stub_data;
          imu_done = 1'b1;
        end
      end
      if (imu_start && !stub_never) stub_remain = stub_delay;
    end
  end

  // jb_imu stub for the overrun instance: ignores every first request, answers the retry
  int                   stub2_remain = 0;
  bit                   stub2_skip   = 1'b1;
  logic [IMU_BUS_W-1:0] exp2_q[$];

  always @(negedge clock) begin
    imu_done_2 = 1'b0;
    if (!reset) begin
      stub2_remain = 0;
      stub2_skip   = 1'b1;
    end else begin
      if (stub2_remain > 0) begin
        stub2_remain--;
        if (stub2_remain == 0) begin
          imu_data_2 = rand_bus();
          imu_done_2 = 1'b1;
          exp2_q.push_back(imu_data_2);
        end
      end
      if (imu_start_2) begin
        if (stub2_skip) begin
          stub2_skip = 1'b0;
        end else begin
          stub2_remain = 10;
          stub2_skip   = 1'b1;
        end
      end
    end
  end

  function automatic bit evt(input int which);
    case (which)
      0:       return imu_start;
      1:       return sample_valid;
      2:       return imu_start_2;
      default: return sample_valid_2;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (evt(which)) begin
        t = cyc;
        return;
      end
    end
  endtask

  task automatic count_evt(input int which, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      if (evt(which)) n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, t1, t2, tv, s, n, rel, prev, delay;
    logic [IMU_BUS_W-1:0] exp_data;
    logic [IMU_BUS_W-1:0] last_exp;

    reset    = 1'b0;
    enable   = 1'b0;
    enable_2 = 1'b0;
    repeat (4) @(negedge clock);

    chk("rst_imu_start", imu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample", sample, 0);
    chk("rst_sample_count", sample_count, 0);
    chk("rst_overrun", overrun_count, 0);
`ifdef IMU_STALE_CHECK_EN
    chk("rst_stale_count", stale_count, 0);
`endif

    // Reference pattern 0x0101..0x0909, roll in the most significant word
    for (int k = 0; k < IMU_WORDS; k++)
      exp_data[(IMU_WORDS-1-k)*IMU_WORD_W +: IMU_WORD_W] = {8'(k+1), 8'(k+1)};
    stub_data  = exp_data;
    stub_delay = 20;
    delay      = 20;

    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b1;

    // Reset asserted while a transaction is outstanding
    wait_evt(0, 300, t);
    chk("pre_reset_start_seen", (t >= 0), 1);
    repeat (5) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_imu_start", imu_start, 0);
    chk("midreset_fault", fault, 0);
    chk("midreset_count", sample_count, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    rel   = cyc;

    // Normal polling: starts every POLL_DIV cycles, sample one cycle after done
    prev = rel;
    for (int i = 0; i < 3; i++) begin
      wait_evt(0, 250, t);
      chk("poll_start_seen", (t >= 0), 1);
      chk("poll_start_period", t - prev, POLL_DIV);
      prev = t;
      wait_evt(1, 100, tv);
      chk("poll_valid_seen", (tv >= 0), 1);
      chk("poll_valid_latency", tv - t, delay + 1);
      chk("poll_sample", sample, exp_data);
      chk("poll_sample_count", sample_count, i + 1);
      chk("poll_busy_in_latch", busy, 1);
      @(negedge clock);
      chk("poll_valid_one_cycle", sample_valid, 0);
      last_exp   = exp_data;
      exp_data   = rand_bus();
      stub_data  = exp_data;
      delay      = $urandom_range(5, 45);
      stub_delay = delay;
    end

    // Lost transactions: two retries one timeout apart, then a sticky fault
    stub_never = 1'b1;
    wait_evt(0, 250, t0);
    chk("lost_start_seen", (t0 >= 0), 1);
    wait_evt(0, 60, t1);
    chk("retry1_gap", t1 - t0, TIMEOUT_CYC + 1);
    wait_evt(0, 60, t2);
    chk("retry2_gap", t2 - t1, TIMEOUT_CYC + 1);
    count_evt(0, 60, n);
    chk("no_third_retry", n, 0);
    chk("fault_set", fault, 1);
    chk("fault_not_busy", busy, 0);
    count_evt(0, 250, n);
    chk("fault_no_start", n, 0);
    chk("fault_sticky", fault, 1);
    chk("fault_overrun", overrun_count, 0);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    chk("fault_cleared", fault, 0);
    chk("fault_idle_busy", busy, 0);
    stub_never = 1'b0;

    // Disable during WAIT_DONE: transaction completes, then no further polling
    exp_data   = rand_bus();
    stub_data  = exp_data;
    stub_delay = 15;
    enable     = 1'b1;
    wait_evt(0, 260, s);
    chk("drop_start_seen", (s >= 0), 1);
    repeat (5) @(negedge clock);
    enable = 1'b0;
    wait_evt(1, 40, tv);
    chk("drop_valid_latency", tv - s, 16);
    chk("drop_sample", sample, exp_data);
    chk("drop_sample_count", sample_count, 4);
    count_evt(0, 450, n);
    chk("drop_no_restart", n, 0);
    chk("drop_idle_busy", busy, 0);
    last_exp = exp_data;

    // Same data delivered twice in a row
    exp_data   = ~last_exp;
    stub_data  = exp_data;
    stub_delay = 10;
    enable     = 1'b1;
    wait_evt(1, 300, tv);
    chk("dup1_valid_seen", (tv >= 0), 1);
    chk("dup1_sample", sample, exp_data);
    chk("dup1_sample_count", sample_count, 5);
    wait_evt(0, 250, s);
    chk("dup2_start_seen", (s >= 0), 1);
`ifdef IMU_STALE_CHECK_EN
    count_evt(1, 30, n);
    chk("dup2_no_valid", n, 0);
    chk("dup2_stale_count", stale_count, 1);
    chk("dup2_sample_count", sample_count, 5);
    chk("dup2_sample", sample, exp_data);
`else
    wait_evt(1, 30, tv);
    chk("dup2_valid_seen", (tv >= 0), 1);
    chk("dup2_sample_count", sample_count, 6);
    chk("dup2_sample", sample, exp_data);
`endif
    enable = 1'b0;

    // Overrun: each transaction straddles one tick, so every other tick is dropped
    enable_2 = 1'b1;
    prev = -1;
    for (int k = 1; k <= 3; k++) begin
      wait_evt(2, 150, t0);
      chk("ovr_first_start_seen", (t0 >= 0), 1);
      if (prev >= 0) chk("ovr_start_period", t0 - prev, 2 * POLL_DIV_2);
      prev = t0;
      wait_evt(2, 60, t1);
      chk("ovr_retry_gap", t1 - t0, TIMEOUT_CYC + 1);
      wait_evt(3, 30, tv);
      chk("ovr_valid_latency", tv - t1, 11);
      if (exp2_q.size() > 0) chk("ovr_sample", sample_2, exp2_q.pop_front());
      else chk("ovr_sample_queued", exp2_q.size(), 1);
      chk("ovr_sample_count", sample_count_2, k);
      chk("ovr_overrun_count", overrun_count_2, k);
      chk("ovr_no_fault", fault_2, 0);
    end
    enable_2 = 1'b0;
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
